// File: rtl/svm_ovo_vote_ctrl.sv
// One-vs-one voting controller: sequences class pairs through binarySVM, tallies votes, argmax-selects the winner.
// Latency: one binarySVM pass per pair, then N_CLASSES scan cycles plus one cycle to present class_out/valid.
// Backpressure: none; pair advance is paced solely by svm_ready, and start is ignored while busy.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 classification request (accepted in IDLE/DONE only)
//   svm_class, svm_ready  decision and end-of-pass strobe from binarySVM
//   svm_rst_n             registered reset to binarySVM, high only while running pairs
//   pair_sel, pair_a/b    current pair index and its two classes (weight/bias mux select)
//   busy                  high while running pairs or scanning votes
//   class_out, valid      winning class and its one-cycle update strobe
module svm_ovo_vote_ctrl #(
    parameter int N_CLASSES = 7,
    parameter int N_PAIRS   = N_CLASSES * (N_CLASSES - 1) / 2,
    parameter int CLASS_W   = $clog2(N_CLASSES),
    parameter int PAIR_W    = $clog2(N_PAIRS),
    parameter int VOTE_W    = $clog2(N_CLASSES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               svm_class,
    input  logic               svm_ready,
    output logic               svm_rst_n,
    output logic [PAIR_W-1:0]  pair_sel,
    output logic [CLASS_W-1:0] pair_a,
    output logic [CLASS_W-1:0] pair_b,
    output logic               busy,
    output logic [CLASS_W-1:0] class_out,
    output logic               valid
);

    // Scan index must be able to hold N_CLASSES itself to mark scan completion.
    localparam int SCAN_W = $clog2(N_CLASSES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [VOTE_W-1:0]  votes [N_CLASSES];
    logic [SCAN_W-1:0]  scan_idx;
    logic [CLASS_W-1:0] best_idx;
    logic [VOTE_W-1:0]  best_cnt;

    logic               start_ok;
    logic               last_pair;
    logic               row_end;
    logic               scan_done;
    logic [CLASS_W-1:0] scan_cls;
    logic [CLASS_W-1:0] vote_cls;

    always_comb begin
        start_ok  = start && ((state == IDLE) || (state == DONE));
        last_pair = (pair_sel == PAIR_W'(N_PAIRS - 1));
        row_end   = (pair_b == CLASS_W'(N_CLASSES - 1));
        scan_done = (scan_idx == SCAN_W'(N_CLASSES));
        scan_cls  = scan_idx[CLASS_W-1:0];
        // svm_class = 0 favours the first class of the pair.
        vote_cls  = svm_class ? pair_b : pair_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            svm_rst_n <= 1'b0;
            pair_sel  <= '0;
            pair_a    <= '0;
            pair_b    <= '0;
            busy      <= 1'b0;
            class_out <= '0;
            valid     <= 1'b0;
            scan_idx  <= '0;
            best_idx  <= '0;
            best_cnt  <= '0;
            for (int i = 0; i < N_CLASSES; i++) begin
                votes[i] <= '0;
            end
        end else begin
            valid <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state     <= RUN;
                        svm_rst_n <= 1'b1;
                        busy      <= 1'b1;
                        pair_sel  <= '0;
                        pair_a    <= '0;
                        pair_b    <= CLASS_W'(1);
                        for (int i = 0; i < N_CLASSES; i++) begin
                            votes[i] <= '0;
                        end
                    end
                end

                RUN: begin
                    if (svm_ready) begin
                        votes[vote_cls] <= votes[vote_cls] + VOTE_W'(1);
                        if (last_pair) begin
                            state     <= ARGMAX;
                            svm_rst_n <= 1'b0;
                            pair_sel  <= '0;
                            pair_a    <= '0;
                            pair_b    <= '0;
                            scan_idx  <= '0;
                            best_idx  <= '0;
                            best_cnt  <= '0;
                        end else begin
                            // Advance in the same edge so the next pair's weights are
                            // already selected when binarySVM restarts its feature walk.
                            pair_sel <= pair_sel + PAIR_W'(1);
                            if (row_end) begin
                                pair_a <= pair_a + CLASS_W'(1);
                                pair_b <= pair_a + CLASS_W'(2);
                            end else begin
                                pair_b <= pair_b + CLASS_W'(1);
                            end
                        end
                    end
                end

                ARGMAX: begin
                    if (!scan_done) begin
                        // Strict greater-than keeps the lowest index on ties.
                        if (votes[scan_cls] > best_cnt) begin
                            best_cnt <= votes[scan_cls];
                            best_idx <= scan_cls;
                        end
                        scan_idx <= scan_idx + SCAN_W'(1);
                    end else begin
                        state     <= DONE;
                        class_out <= best_idx;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_svm_ovo_vote_ctrl.sv
module tb_svm_ovo_vote_ctrl;

    localparam int N  = 7;
    localparam int NP = N * (N - 1) / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       svm_class;
    logic       svm_ready;
    logic       svm_rst_n;
    logic [4:0] pair_sel;
    logic [2:0] pair_a;
    logic [2:0] pair_b;
    logic       busy;
    logic [2:0] class_out;
    logic       valid;

    svm_ovo_vote_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .svm_class (svm_class),
        .svm_ready (svm_ready),
        .svm_rst_n (svm_rst_n),
        .pair_sel  (pair_sel),
        .pair_a    (pair_a),
        .pair_b    (pair_b),
        .busy      (busy),
        .class_out (class_out),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_a [NP];
    int exp_b [NP];
    bit dec   [NP];
    int last_class = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference: tally each pair's winner, then pick the highest count, lowest index on ties.
    function automatic int model_winner();
        int v [N];
        int p;
        int best;
        for (int c = 0; c < N; c++) v[c] = 0;
        p = 0;
        for (int a = 0; a < N; a++) begin
            for (int b = a + 1; b < N; b++) begin
                if (dec[p]) v[b]++;
                else        v[a]++;
                p++;
            end
        end
        best = 0;
        for (int c = 1; c < N; c++) begin
            if (v[c] > v[best]) best = c;
        end
        return best;
    endfunction

    // Class 2 beats all but class 0, class 4 beats all but class 2, the rest: higher class wins.
    // Tally: {1,1,5,2,5,3,4}.
    function automatic bit tie_dec(input int a, input int b);
        if (a == 0 && b == 2)      return 1'b0;
        if (a == 2)                return 1'b0;
        if (b == 2)                return 1'b1;
        if (a == 4)                return 1'b0;
        if (b == 4)                return 1'b1;
        return 1'b1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_svm_rst_n"}, 32'(svm_rst_n), 0);
        check({tag, "_pair_sel"},  32'(pair_sel),  0);
        check({tag, "_pair_a"},    32'(pair_a),    0);
        check({tag, "_pair_b"},    32'(pair_b),    0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_class_out"}, 32'(class_out), 0);
        check({tag, "_valid"},     32'(valid),     0);
    endtask

    // One full classification. Returns early (with rst_n asserted) when abort_at hits.
    // With chain=1, start is raised in the valid cycle and left high for the next call.
    task automatic run_class(input bit skip_start, input bit busy_starts, input int abort_at,
                             input bit chain);
        int exp_w;
        int gap;
        exp_w = model_winner();
        if (!skip_start) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check("start_busy",      32'(busy),      1);
        check("start_svm_rst_n", 32'(svm_rst_n), 1);
        check("start_valid",     32'(valid),     0);

        for (int p = 0; p < NP; p++) begin
            gap = int'($urandom_range(1, 5));
            repeat (gap) begin
                @(negedge clk);
                svm_class = 1'($urandom);
            end
            if (busy_starts && p == 5) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (p == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                return;
            end
            check("run_pair_sel",  32'(pair_sel),  p);
            check("run_pair_a",    32'(pair_a),    exp_a[p]);
            check("run_pair_b",    32'(pair_b),    exp_b[p]);
            check("run_svm_rst_n", 32'(svm_rst_n), 1);
            check("run_busy",      32'(busy),      1);
            svm_ready = 1'b1;
            svm_class = dec[p];
            @(negedge clk);
            svm_ready = 1'b0;
            svm_class = 1'($urandom);
        end

        // Now one edge past the last ready.
        check("end_svm_rst_n", 32'(svm_rst_n), 0);
        check("end_pair_sel",  32'(pair_sel),  0);
        check("end_pair_a",    32'(pair_a),    0);
        check("end_pair_b",    32'(pair_b),    0);
        for (int k = 1; k <= N + 1; k++) begin
            if (k > 1) @(negedge clk);
            start = (busy_starts && k == 2);
            check("scan_valid",     32'(valid),     0);
            check("scan_busy",      32'(busy),      1);
            check("scan_class_out", 32'(class_out), last_class);
        end
        @(negedge clk);
        start = chain;
        check("done_valid",     32'(valid),     1);
        check("done_busy",      32'(busy),      0);
        check("done_class_out", 32'(class_out), exp_w);
        last_class = exp_w;
        if (!chain) begin
            @(negedge clk);
            check("post_valid",     32'(valid),     0);
            check("post_class_out", 32'(class_out), exp_w);
        end
    endtask

    initial begin
        int p;
        rst_n     = 1'b0;
        start     = 1'b0;
        svm_class = 1'b0;
        svm_ready = 1'b0;

        p = 0;
        for (int a = 0; a < N; a++) begin
            for (int b = a + 1; b < N; b++) begin
                exp_a[p] = a;
                exp_b[p] = b;
                p++;
            end
        end

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All decisions favour the first class: class 0 wins with 6 votes.
        for (int i = 0; i < NP; i++) dec[i] = 1'b0;
        run_class(1'b0, 1'b0, -1, 1'b0);
        check("all0_class", 32'(class_out), 0);

        // All decisions favour the second class: class 6 wins with 6 votes.
        for (int i = 0; i < NP; i++) dec[i] = 1'b1;
        run_class(1'b0, 1'b0, -1, 1'b0);
        check("all1_class", 32'(class_out), 6);

        // Classes 2 and 4 tie at five votes: lower index wins.
        for (int i = 0; i < NP; i++) dec[i] = tie_dec(exp_a[i], exp_b[i]);
        run_class(1'b0, 1'b0, -1, 1'b0);
        check("tie_class", 32'(class_out), 2);

        // start pulses during RUN and ARGMAX are ignored.
        for (int i = 0; i < NP; i++) dec[i] = bit'($urandom_range(0, 1));
        run_class(1'b0, 1'b1, -1, 1'b0);

        // Reset mid-run at pair 10: everything returns to reset values, no valid.
        for (int i = 0; i < NP; i++) dec[i] = bit'($urandom_range(0, 1));
        run_class(1'b0, 1'b0, 10, 1'b0);
        last_class = 0;
        repeat (3) begin
            @(negedge clk);
            svm_ready = ~svm_ready;
        end
        svm_ready = 1'b0;
        rst_n     = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            svm_ready = k[0];
            check("idle_valid",     32'(valid),     0);
            check("idle_busy",      32'(busy),      0);
            check("idle_pair_sel",  32'(pair_sel),  0);
            check("idle_svm_rst_n", 32'(svm_rst_n), 0);
        end
        svm_ready = 1'b0;

        for (int i = 0; i < NP; i++) dec[i] = 1'b0;
        run_class(1'b0, 1'b0, -1, 1'b0);
        check("fresh_class", 32'(class_out), 0);

        // start in the valid cycle: second run must not inherit the first run's votes.
        for (int i = 0; i < NP; i++) dec[i] = 1'b0;
        run_class(1'b0, 1'b0, -1, 1'b1);
        for (int i = 0; i < NP; i++) dec[i] = 1'b1;
        run_class(1'b1, 1'b0, -1, 1'b0);
        check("chain_class", 32'(class_out), 6);

        // Random decision patterns.
        repeat (4) begin
            for (int i = 0; i < NP; i++) dec[i] = bit'($urandom_range(0, 1));
            run_class(1'b0, 1'b0, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/svm_ovo_vote_ctrl.md
# svm_ovo_vote_ctrl

One-vs-one voting controller for the sequential multiclass SVM. It sits directly downstream of the serial `binarySVM` datapath and drives it. For each class pair it selects the pair's weight/bias set, gates the binary classifier's reset so each pass starts cleanly, and collects each `class_o` decision as a vote. After all pairs are evaluated it runs a sequential argmax over the vote counters and presents the winning class with a one-cycle valid strobe.

## Interface

Parameters:
- `N_CLASSES`, default 7. Number of output classes; must be ≥ 2.
- `N_PAIRS`, default `N_CLASSES*(N_CLASSES-1)/2`. Derived; do not override.
- `CLASS_W`, default `$clog2(N_CLASSES)`. Width of class indices.
- `PAIR_W`, default `$clog2(N_PAIRS)`. Width of the pair index.
- `VOTE_W`, default `$clog2(N_CLASSES)`. Vote counter width; the maximum vote count is `N_CLASSES-1`.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all flops on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a classification; sampled only in IDLE or DONE.
- `svm_class`  in  1  `class_o` from `binarySVM`. 0 = vote for `pair_a`, 1 = vote for `pair_b`.
- `svm_ready`  in  1  `ready` from `binarySVM`. High for one cycle at the end of each pass.
- `svm_rst_n`  out  1  registered active-low reset to `binarySVM`. High only in RUN.
- `pair_sel`  out  PAIR_W  current pair index; drives the weight/bias mux.
- `pair_a`  out  CLASS_W  first class of the current pair.
- `pair_b`  out  CLASS_W  second class of the current pair.
- `busy`  out  1  high in RUN and ARGMAX.
- `class_out`  out  CLASS_W  winning class; held until the next accepted `start`.
- `valid`  out  1  one-cycle pulse when `class_out` updates.

## Operation

- States and transitions:
  - IDLE: → RUN on `start`.
  - RUN: → ARGMAX on the `svm_ready` that ends the last pair.
  - ARGMAX: → DONE after the scan completes.
  - DONE: → RUN on `start`; otherwise stays in DONE.
- Pair order is lexicographic: (0,1), (0,2) … (0,N-1), (1,2) … (N-2,N-1).
  - `pair_sel` runs 0 … N_PAIRS-1.
  - `pair_a` and `pair_b` are generated by counters, not a ROM.
- On an accepted `start`:
  - clear all vote counters;
  - set `pair_sel`=0, `pair_a`=0, `pair_b`=1;
  - set `svm_rst_n` high from the next cycle.
- In RUN, on each cycle with `svm_ready`=1:
  - increment the vote counter of `pair_a` if `svm_class`=0, else of `pair_b`;
  - advance the pair counters in the same edge, so the new weights are present when `binarySVM` wraps its feature index to 0.
  - `svm_ready` outside RUN is ignored.
- Pair counter wrap: when `pair_b`=N_CLASSES-1, set `pair_b`=`pair_a`+2 and `pair_a`=`pair_a`+1.
- On the last pair's ready edge:
  - record the vote;
  - go to ARGMAX;
  - drive `svm_rst_n` low;
  - return `pair_sel`, `pair_a`, `pair_b` to 0.
- ARGMAX scans one class per cycle, indices 0 … N_CLASSES-1.
  - Compare with a strict greater-than, so ties resolve to the lowest class index.
  - The best index and best count are registered.
- DONE: load `class_out` from the best index and pulse `valid` for one cycle. `busy` is low.
- `start` while `busy`=1 is ignored, with no restart and no effect on votes.
- `start` in the same cycle as `valid` is accepted.
- Vote counters cannot overflow: the maximum count is N_CLASSES-1, which fits VOTE_W. No saturation logic.

## Timing

- Reset values: `svm_rst_n`=0, `pair_sel`=0, `pair_a`=0, `pair_b`=0, `busy`=0, `class_out`=0, `valid`=0, all votes 0, state IDLE.
- Asserting `rst_n` mid-operation aborts the classification immediately. No partial result is presented.
- `start` sampled at edge E: `busy`=1 and `svm_rst_n`=1 from edge E onward.
- Each pair occupies one `binarySVM` pass. With F features, `svm_ready` recurs every F+1 cycles. The controller relies only on `svm_ready`, never on F.
- From the edge sampling the last `svm_ready`:
  - N_CLASSES scan edges follow;
  - `valid` is high in the cycle after the following edge, i.e. N_CLASSES+1 edges after the last ready.
- `busy` falls in the same edge that raises `valid`.
- `class_out` changes only in the edge that raises `valid`.

## Test plan

- Default parameters (N_CLASSES=7, N_PAIRS=21), `svm_class` held 0, `svm_ready` pulsed every 10 cycles → `pair_sel` steps 0…20 with correct (a,b); votes = {6,5,4,3,2,1,0}; `class_out`=0; single `valid` pulse N_CLASSES+1 edges after the last ready.
- `svm_class` held 1 → votes = {0,1,2,3,4,5,6}; `class_out`=6.
- Per-pair decisions giving class 2 and class 4 five votes each, all others fewer → `class_out`=2 (lowest-index tie-break).
- `start` pulsed during RUN at pair 5 and during ARGMAX → no restart, votes and result unchanged; `svm_rst_n` stays high through RUN.
- `rst_n` asserted at pair 10, then released → all outputs at reset values, `valid` never pulses; a fresh `start` with all-0 decisions → `class_out`=0.
- `start` in the `valid` cycle → accepted; votes cleared; second result correct and independent of the first.
